// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: commit FSM states, ROB index width and reset PC.
package rv32i_types;

  localparam int unsigned ROB_IDX_W = 5;
  localparam logic [31:0] RESET_PC  = 32'h1eceb000;

  typedef enum logic [1:0] {
    RUN,
    STORE_WAIT,
    DRAIN
  } commit_state_t;

endpackage

// File: rtl/rob_commit_perf_counters.sv
// Retire and mispredict event counters; both wrap at their natural width.
module perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        retire_i,
  input  logic        mispred_i,
  output logic [63:0] retired_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  logic [63:0] retired_q;
  logic [31:0] mispred_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      mispred_q <= '0;
    end else begin
      if (retire_i)  retired_q <= retired_q + 64'd1;
      if (mispred_i) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign retired_cnt_o = retired_q;
  assign mispred_cnt_o = mispred_q;

endmodule

// File: rtl/rob_commit.sv
// In-order retire stage: drains the ROB head, writes the ARF, releases stores
// and raises a one-cycle flush with redirect PC on a mispredicted branch.
module rob_commit
  import rv32i_types::*;
#(
  parameter int unsigned ROB_DEPTH = 32,
  parameter logic [31:0] RESET_PC  = rv32i_types::RESET_PC
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         head_valid_i,
  input  logic                         head_done_i,
  input  logic [$clog2(ROB_DEPTH)-1:0] head_rob_idx_i,
  input  logic [31:0]                  head_pc_i,
  input  logic [31:0]                  head_inst_i,
  input  logic                         head_regf_we_i,
  input  logic [4:0]                   head_rd_addr_i,
  input  logic [31:0]                  head_rd_data_i,
  input  logic                         head_is_store_i,
  input  logic                         head_is_branch_i,
  input  logic                         head_pred_taken_i,
  input  logic                         head_br_en_i,
  input  logic [31:0]                  head_pc_new_i,
  input  logic                         store_ack_i,
  output logic                         dequeue_o,
  output logic                         regf_we_o,
  output logic [4:0]                   regf_addr_o,
  output logic [31:0]                  regf_data_o,
  output logic [$clog2(ROB_DEPTH)-1:0] rat_clr_idx_o,
  output logic                         store_commit_o,
  output logic                         flush_o,
  output logic [31:0]                  redirect_pc_o,
  output logic [63:0]                  retired_cnt_o,
  output logic [31:0]                  mispred_cnt_o
);

  localparam int unsigned IdxW = $clog2(ROB_DEPTH);

  commit_state_t   state_q;
  logic            regf_we_q;
  logic [4:0]      regf_addr_q;
  logic [31:0]     regf_data_q;
  logic [IdxW-1:0] rat_clr_idx_q;
  logic            store_commit_q;
  logic            flush_q;
  logic [31:0]     redirect_pc_q;

  logic head_ready;
  logic mispred;
  logic mispred_retire;
  logic unused_inst;

  assign unused_inst = ^head_inst_i;

  assign head_ready = head_valid_i & head_done_i;
  // A store flagged as a branch is still handled as a store.
  assign mispred    = head_is_branch_i & (head_br_en_i != head_pred_taken_i) & ~head_is_store_i;

  always_comb begin
    dequeue_o = 1'b0;
    case (state_q)
      RUN:        dequeue_o = head_ready & ~head_is_store_i;
      STORE_WAIT: dequeue_o = store_ack_i;
      default:    dequeue_o = 1'b0;
    endcase
    if (rst) dequeue_o = 1'b0;
  end

  assign mispred_retire = (state_q == RUN) & head_ready & mispred & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      regf_we_q      <= 1'b0;
      regf_addr_q    <= '0;
      regf_data_q    <= '0;
      rat_clr_idx_q  <= '0;
      store_commit_q <= 1'b0;
      flush_q        <= 1'b0;
      redirect_pc_q  <= RESET_PC;
    end else begin
      regf_we_q <= 1'b0;
      flush_q   <= 1'b0;
      case (state_q)
        RUN: begin
          if (head_ready) begin
            if (head_is_store_i) begin
              store_commit_q <= 1'b1;
              state_q        <= STORE_WAIT;
            end else begin
              if (head_regf_we_i && (head_rd_addr_i != 5'd0)) begin
                regf_we_q     <= 1'b1;
                regf_addr_q   <= head_rd_addr_i;
                regf_data_q   <= head_rd_data_i;
                rat_clr_idx_q <= head_rob_idx_i;
              end
              if (mispred) begin
                flush_q       <= 1'b1;
                redirect_pc_q <= head_br_en_i ? head_pc_new_i : head_pc_i + 32'd4;
                state_q       <= DRAIN;
              end
            end
          end
        end
        STORE_WAIT: begin
          if (store_ack_i) begin
            store_commit_q <= 1'b0;
            state_q        <= RUN;
          end
        end
        DRAIN:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign regf_we_o      = regf_we_q;
  assign regf_addr_o    = regf_addr_q;
  assign regf_data_o    = regf_data_q;
  assign rat_clr_idx_o  = rat_clr_idx_q;
  assign store_commit_o = store_commit_q;
  assign flush_o        = flush_q;
  assign redirect_pc_o  = redirect_pc_q;

  perf_counters u_perf_counters (
    .clk           (clk),
    .rst           (rst),
    .retire_i      (dequeue_o),
    .mispred_i     (mispred_retire),
    .retired_cnt_o (retired_cnt_o),
    .mispred_cnt_o (mispred_cnt_o)
  );

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: ALU retire, store handshake, mispredict flush, reset.
module tb_rob_commit;

  logic        clk = 1'b0;
  logic        rst;
  logic        head_valid_i, head_done_i;
  logic [4:0]  head_rob_idx_i;
  logic [31:0] head_pc_i, head_inst_i;
  logic        head_regf_we_i;
  logic [4:0]  head_rd_addr_i;
  logic [31:0] head_rd_data_i;
  logic        head_is_store_i, head_is_branch_i, head_pred_taken_i, head_br_en_i;
  logic [31:0] head_pc_new_i;
  logic        store_ack_i;
  logic        dequeue_o, regf_we_o;
  logic [4:0]  regf_addr_o;
  logic [31:0] regf_data_o;
  logic [4:0]  rat_clr_idx_o;
  logic        store_commit_o, flush_o;
  logic [31:0] redirect_pc_o;
  logic [63:0] retired_cnt_o;
  logic [31:0] mispred_cnt_o;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  rob_commit dut (
    .clk               (clk),
    .rst               (rst),
    .head_valid_i      (head_valid_i),
    .head_done_i       (head_done_i),
    .head_rob_idx_i    (head_rob_idx_i),
    .head_pc_i         (head_pc_i),
    .head_inst_i       (head_inst_i),
    .head_regf_we_i    (head_regf_we_i),
    .head_rd_addr_i    (head_rd_addr_i),
    .head_rd_data_i    (head_rd_data_i),
    .head_is_store_i   (head_is_store_i),
    .head_is_branch_i  (head_is_branch_i),
    .head_pred_taken_i (head_pred_taken_i),
    .head_br_en_i      (head_br_en_i),
    .head_pc_new_i     (head_pc_new_i),
    .store_ack_i       (store_ack_i),
    .dequeue_o         (dequeue_o),
    .regf_we_o         (regf_we_o),
    .regf_addr_o       (regf_addr_o),
    .regf_data_o       (regf_data_o),
    .rat_clr_idx_o     (rat_clr_idx_o),
    .store_commit_o    (store_commit_o),
    .flush_o           (flush_o),
    .redirect_pc_o     (redirect_pc_o),
    .retired_cnt_o     (retired_cnt_o),
    .mispred_cnt_o     (mispred_cnt_o)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; returns 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Comb outputs settle a moment after inputs change.
  task automatic settle();
    #1;
  endtask

  task automatic idle_head();
    head_valid_i = 0; head_done_i = 0; head_rob_idx_i = '0; head_pc_i = '0;
    head_inst_i = 32'h0000_0013; head_regf_we_i = 0; head_rd_addr_i = '0;
    head_rd_data_i = '0; head_is_store_i = 0; head_is_branch_i = 0;
    head_pred_taken_i = 0; head_br_en_i = 0; head_pc_new_i = '0;
  endtask

  task automatic alu_head(input logic [4:0] idx, input logic [4:0] rd, input logic [31:0] data);
    idle_head();
    head_valid_i = 1; head_done_i = 1; head_rob_idx_i = idx;
    head_regf_we_i = 1; head_rd_addr_i = rd; head_rd_data_i = data;
  endtask

  task automatic store_head(input logic [4:0] idx);
    idle_head();
    head_valid_i = 1; head_done_i = 1; head_rob_idx_i = idx; head_is_store_i = 1;
  endtask

  task automatic branch_head(input logic [31:0] pc, input logic pred, input logic br,
                             input logic [31:0] tgt);
    idle_head();
    head_valid_i = 1; head_done_i = 1; head_is_branch_i = 1; head_pc_i = pc;
    head_pred_taken_i = pred; head_br_en_i = br; head_pc_new_i = tgt;
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } alu_vec_t;

  initial begin
    alu_vec_t alu_vecs[3];
    alu_vecs[0] = '{rd: 5'd5, data: 32'd11};
    alu_vecs[1] = '{rd: 5'd6, data: 32'd22};
    alu_vecs[2] = '{rd: 5'd0, data: 32'd33};

    idle_head();
    store_ack_i = 0;
    rst = 1;
    step();
    step();
    check_val("rst_dequeue",  dequeue_o, 0);
    check_val("rst_regf_we",  regf_we_o, 0);
    check_val("rst_store",    store_commit_o, 0);
    check_val("rst_flush",    flush_o, 0);
    check_val("rst_redirect", redirect_pc_o, 64'h1eceb000);
    check_val("rst_retired",  retired_cnt_o, 0);
    check_val("rst_mispred",  mispred_cnt_o, 0);

    // Idle head for five cycles
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_val("idle_dequeue", dequeue_o, 0);
      step();
      check_val("idle_regf_we", regf_we_o, 0);
    end
    check_val("idle_redirect", redirect_pc_o, 64'h1eceb000);
    check_val("idle_retired",  retired_cnt_o, 0);

    // Three back-to-back ALU retires, last one to x0
    for (int i = 0; i < 3; i++) begin
      alu_head(5'(i + 1), alu_vecs[i].rd, alu_vecs[i].data);
      settle();
      check_val("alu_dequeue", dequeue_o, 1);
      step();
      check_val("alu_regf_we", regf_we_o, (alu_vecs[i].rd != 0) ? 1 : 0);
      if (i < 2) begin
        check_val("alu_regf_addr", regf_addr_o, alu_vecs[i].rd);
        check_val("alu_regf_data", regf_data_o, alu_vecs[i].data);
        check_val("alu_rat_idx",   rat_clr_idx_o, i + 1);
      end
    end
    idle_head();
    check_val("alu_retired", retired_cnt_o, 3);

    // Store: request held three cycles, ack in the third
    store_head(5'd9);
    settle();
    check_val("st_no_deq_run", dequeue_o, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("st_commit_high", store_commit_o, 1);
      if (i == 2) store_ack_i = 1;
      settle();
      check_val("st_dequeue", dequeue_o, (i == 2) ? 1 : 0);
    end
    step();
    store_ack_i = 0;
    idle_head();
    check_val("st_commit_drop", store_commit_o, 0);
    check_val("st_retired",     retired_cnt_o, 4);

    // Mispredicted taken branch with link write (jal-like)
    branch_head(32'h0000_1000, 1'b0, 1'b1, 32'h0000_2000);
    head_regf_we_i = 1; head_rd_addr_i = 5'd1; head_rd_data_i = 32'h0000_1004;
    head_rob_idx_i = 5'd12;
    settle();
    check_val("br_dequeue", dequeue_o, 1);
    step();
    check_val("br_flush",    flush_o, 1);
    check_val("br_redirect", redirect_pc_o, 64'h2000);
    check_val("br_link_we",  regf_we_o, 1);
    check_val("br_link_rd",  regf_addr_o, 1);
    check_val("br_link_val", regf_data_o, 64'h1004);
    check_val("br_mispred",  mispred_cnt_o, 1);
    check_val("br_retired",  retired_cnt_o, 5);
    settle();
    check_val("drain_no_deq", dequeue_o, 0);
    step();
    idle_head();
    check_val("br_flush_pulse", flush_o, 0);
    check_val("drain_retired",  retired_cnt_o, 5);

    // Predicted-taken, resolved not-taken at top of address space
    branch_head(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0000_1234);
    settle();
    check_val("wrap_dequeue", dequeue_o, 1);
    step();
    check_val("wrap_flush",    flush_o, 1);
    check_val("wrap_redirect", redirect_pc_o, 64'h0);
    check_val("wrap_mispred",  mispred_cnt_o, 2);
    step();
    idle_head();
    check_val("wrap_flush_pulse", flush_o, 0);

    // Correctly predicted branch retires without flush
    branch_head(32'h0000_3000, 1'b1, 1'b1, 32'h0000_4000);
    settle();
    check_val("okbr_dequeue", dequeue_o, 1);
    step();
    idle_head();
    check_val("okbr_flush",   flush_o, 0);
    check_val("okbr_mispred", mispred_cnt_o, 2);
    check_val("okbr_retired", retired_cnt_o, 7);

    // Reset while waiting on a store ack
    store_head(5'd20);
    step();
    check_val("rst_st_commit", store_commit_o, 1);
    rst = 1;
    store_ack_i = 1;
    settle();
    check_val("rst_st_no_deq", dequeue_o, 0);
    step();
    check_val("rst_st_drop",    store_commit_o, 0);
    check_val("rst_st_retired", retired_cnt_o, 0);
    check_val("rst_st_mispred", mispred_cnt_o, 0);
    rst = 0;
    store_ack_i = 0;
    alu_head(5'd3, 5'd7, 32'd77);
    settle();
    check_val("post_rst_deq", dequeue_o, 1);
    step();
    idle_head();
    check_val("post_rst_we",      regf_we_o, 1);
    check_val("post_rst_addr",    regf_addr_o, 7);
    check_val("post_rst_data",    regf_data_o, 77);
    check_val("post_rst_retired", retired_cnt_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
